// File: rtl/count_sequencer.sv
// Round-robin increment sequencer for a multi-digit counter: captures request edges,
// then runs grant -> carry settle -> output refresh -> debounce holdoff for each one.
module count_sequencer #(
  parameter int DIGITS         = 6,
  parameter int SETTLE_CYCLES  = 17,
  parameter int HOLDOFF_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] req,
  input  logic              enable,
  input  logic              clr_ovr,
  output logic [DIGITS-1:0] inc_sel,
  output logic              inc_pulse,
  output logic              ref_pulse,
  output logic              busy,
  output logic [DIGITS-1:0] pending,
  output logic              overrun
);

  localparam int                IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [13:0]       SETTLE_LAST  = 14'(SETTLE_CYCLES - 1);
  localparam logic [13:0]       HOLDOFF_LAST = 14'(HOLDOFF_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_DIGIT   = IDX_W'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SETTLE,
    REFRESH,
    HOLDOFF
  } state_t;

  state_t            state;
  logic [13:0]       cnt;
  logic [DIGITS-1:0] req_prev;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  next_grant;
  logic [DIGITS-1:0] next_sel;
  logic [DIGITS-1:0] edges;
  logic [DIGITS-1:0] set_mask;
  logic [DIGITS-1:0] clr_mask;
  logic              ovr_event;

  // inc_sel is only non-zero during GRANT, so it doubles as the pending clear mask;
  // a fresh edge on the granted digit in that cycle therefore re-arms it cleanly.
  always_comb begin
    edges     = req & ~req_prev;
    set_mask  = enable ? edges : '0;
    clr_mask  = inc_sel;
    ovr_event = |(set_mask & pending & ~clr_mask);
  end

  // Scanning offsets from the farthest down to the nearest lets the nearest hit win.
  always_comb begin
    int idx;
    idx        = 0;
    next_grant = '0;
    for (int off = DIGITS; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= DIGITS) idx -= DIGITS;
      if (pending[IDX_W'(idx)]) next_grant = IDX_W'(idx);
    end
    next_sel = DIGITS'(1) << next_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_prev <= '1;
      pending  <= '0;
      overrun  <= 1'b0;
    end else begin
      req_prev <= req;
      pending  <= (pending & ~clr_mask) | set_mask;
      overrun  <= ovr_event | (overrun & ~clr_ovr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LAST_DIGIT;
      grant      <= '0;
      inc_sel    <= '0;
      inc_pulse  <= 1'b0;
      ref_pulse  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (|pending)) begin
            state     <= GRANT;
            grant     <= next_grant;
            inc_sel   <= next_sel;
            inc_pulse <= 1'b1;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          state      <= SETTLE;
          inc_sel    <= '0;
          inc_pulse  <= 1'b0;
          last_grant <= grant;
          cnt        <= '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state     <= REFRESH;
            ref_pulse <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        REFRESH: begin
          state     <= HOLDOFF;
          ref_pulse <= 1'b0;
          cnt       <= '0;
        end
        HOLDOFF: begin
          if (cnt == HOLDOFF_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          inc_sel   <= '0;
          inc_pulse <= 1'b0;
          ref_pulse <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: per-cycle input schedules, a grant scoreboard and
// timing expectations for busy/ref_pulse derived from the sequence lengths.
module tb_count_sequencer;

  localparam int DIGITS  = 6;
  localparam int SETTLE  = 4;
  localparam int HOLDOFF = 8;
  localparam int SPAN    = 1 + SETTLE + 1 + HOLDOFF;
  localparam int REF_OFS = 1 + SETTLE;
  localparam int MAXT    = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIGITS-1:0] req;
  logic              enable;
  logic              clr_ovr;
  logic [DIGITS-1:0] inc_sel;
  logic              inc_pulse;
  logic              ref_pulse;
  logic              busy;
  logic [DIGITS-1:0] pending;
  logic              overrun;

  always #5 clk = ~clk;

  count_sequencer #(
    .DIGITS(DIGITS),
    .SETTLE_CYCLES(SETTLE),
    .HOLDOFF_CYCLES(HOLDOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .enable(enable),
    .clr_ovr(clr_ovr),
    .inc_sel(inc_sel),
    .inc_pulse(inc_pulse),
    .ref_pulse(ref_pulse),
    .busy(busy),
    .pending(pending),
    .overrun(overrun)
  );

  typedef struct {
    int        at;
    logic [5:0] sel;
  } push_t;

  typedef struct {
    string          name;
    logic [5:0]     req;
    logic           en;
    logic [5:0]     pend;
    int             ngr;
    logic [5:0][5:0] sel;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] s_req  [MAXT];
  logic       s_en   [MAXT];
  logic       s_clr  [MAXT];
  logic       s_rst  [MAXT];
  int         s_ovr  [MAXT];
  logic [5:0] s_pend [MAXT];
  logic       s_pchk [MAXT];
  push_t      push_q[$];
  logic [5:0] exp_q[$];
  int         first_edge;
  int         last_inc;
  int         n_inc;
  logic [5:0] pre_req;
  logic [5:0] fin_pend;
  logic       fin_ovr;
  string      scen;
  vec_t       vecs[5];

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %h, required %h", scen, what, act, exp);
    end
  endtask

  task automatic rangeCheck(input string what, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %0d, required %0d..%0d", scen, what, val, lo, hi);
    end
  endtask

  task automatic clearSchedule();
    for (int t = 0; t < MAXT; t++) begin
      s_req[t]  = '0;
      s_en[t]   = 1'b1;
      s_clr[t]  = 1'b0;
      s_rst[t]  = 1'b0;
      s_ovr[t]  = 0;
      s_pend[t] = '0;
      s_pchk[t] = 1'b0;
    end
    push_q.delete();
    exp_q.delete();
    pre_req    = '0;
    fin_pend   = '0;
    fin_ovr    = 1'b0;
    first_edge = 2;
  endtask

  // Drives the inputs sampled at the next rising edge and queues the grants they cause.
  task automatic applyStimulus(input int t);
    while (push_q.size() > 0 && push_q[0].at == t) begin
      exp_q.push_back(push_q[0].sel);
      push_q.delete(0);
    end
    req     = s_req[t];
    enable  = s_en[t];
    clr_ovr = s_clr[t];
    if (s_rst[t] && !reset) begin
      reset = 1'b1;
      #1;
      check("async_reset", {20'd0, inc_pulse, ref_pulse, busy, pending, 3'd0}, 32'd0);
      last_inc = -1;
      exp_q.delete();
      push_q.delete();
    end else begin
      reset = s_rst[t];
    end
  endtask

  task automatic checkOutput(input int t);
    logic busy_exp;
    logic ref_exp;
    if (inc_pulse) begin
      check("grant_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("grant_sel", 32'(inc_sel), 32'(exp_q[0]));
        exp_q.delete(0);
        if (n_inc == 0) rangeCheck("grant_latency", t, first_edge + 2, first_edge + 3);
        else            rangeCheck("grant_gap", t - last_inc, SPAN, SPAN + 1);
      end
      last_inc = t;
      n_inc++;
    end
    busy_exp = (last_inc >= 0) && (t >= last_inc) && (t < last_inc + SPAN);
    ref_exp  = (last_inc >= 0) && (t == last_inc + REF_OFS);
    check("cycle_outputs", {24'd0, busy, ref_pulse, (inc_pulse ? 6'd0 : inc_sel)},
          {24'd0, busy_exp, ref_exp, 6'd0});
    if (s_ovr[t] >= 0) check("overrun", 32'(overrun), 32'(s_ovr[t]));
    if (s_pchk[t]) check("pending", 32'(pending), 32'(s_pend[t]));
  endtask

  task automatic runScenario(input string name, input int cycles);
    scen     = name;
    last_inc = -1;
    n_inc    = 0;
    @(negedge clk);
    reset   = 1'b1;
    req     = pre_req;
    enable  = 1'b1;
    clr_ovr = 1'b0;
    @(negedge clk);
    check("reset_state", {18'd0, inc_pulse, ref_pulse, busy, overrun, pending, inc_sel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      checkOutput(t);
      applyStimulus(t);
    end
    check("missing_grants", 32'(exp_q.size() + push_q.size()), 32'd0);
    check("final_pending", 32'(pending), 32'(fin_pend));
    check("final_overrun", 32'(overrun), 32'(fin_ovr));
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    enable  = 1'b0;
    clr_ovr = 1'b0;

    // Expected grant lists are written last-grant-first (sel[0] is the rightmost slice).
    vecs[0] = '{"single_d2",   6'b000100, 1'b1, 6'b000100, 1,
                {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b000100}};
    vecs[1] = '{"pair_d0_d3",  6'b001001, 1'b1, 6'b001001, 2,
                {6'd0, 6'd0, 6'd0, 6'd0, 6'b001000, 6'b000001}};
    vecs[2] = '{"disabled_d4", 6'b010000, 1'b0, 6'b000000, 0,
                {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}};
    vecs[3] = '{"triple",      6'b100110, 1'b1, 6'b100110, 3,
                {6'd0, 6'd0, 6'd0, 6'b100000, 6'b000100, 6'b000010}};
    vecs[4] = '{"all_six",     6'b111111, 1'b1, 6'b111111, 6,
                {6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001}};

    foreach (vecs[n]) begin
      clearSchedule();
      s_req[2] = vecs[n].req;
      for (int t = 0; t <= 3; t++) s_en[t] = vecs[n].en;
      s_pchk[3] = 1'b1;
      s_pend[3] = vecs[n].pend;
      for (int i = 0; i < vecs[n].ngr; i++) push_q.push_back('{2, vecs[n].sel[i]});
      runScenario(vecs[n].name, 16 * vecs[n].ngr + 20);
    end

    // Lost edge on a digit already pending, then clear racing a second lost edge.
    clearSchedule();
    s_req[2]  = 6'b000001;
    s_req[6]  = 6'b000010;
    s_req[8]  = 6'b000010;
    s_req[10] = 6'b000010;
    s_clr[10] = 1'b1;
    s_clr[13] = 1'b1;
    for (int t = 9; t <= 13; t++) s_ovr[t] = 1;
    s_pchk[7] = 1'b1;
    s_pend[7] = 6'b000010;
    push_q.push_back('{2, 6'b000001});
    push_q.push_back('{6, 6'b000010});
    runScenario("overrun", 50);

    // New edge on the granted digit during its GRANT cycle re-arms it without overrun.
    clearSchedule();
    s_req[2]  = 6'b000100;
    s_req[4]  = 6'b000100;
    s_pchk[5] = 1'b1;
    s_pend[5] = 6'b000100;
    push_q.push_back('{2, 6'b000100});
    push_q.push_back('{4, 6'b000100});
    runScenario("set_wins", 45);

    clearSchedule();
    pre_req = 6'b111111;
    for (int t = 0; t < MAXT; t++) s_req[t] = 6'b111111;
    runScenario("held_through_reset", 50);

    clearSchedule();
    s_req[2] = 6'b000100;
    s_rst[6] = 1'b1;
    push_q.push_back('{2, 6'b000100});
    runScenario("reset_in_settle", 30);

    clearSchedule();
    s_req[2] = 6'b000011;
    for (int t = 6; t < MAXT; t++) s_en[t] = 1'b0;
    fin_pend = 6'b000010;
    push_q.push_back('{2, 6'b000001});
    runScenario("enable_drop", 40);

    // Last grant on the top digit: the next search wraps to digit 0 before digit 4.
    clearSchedule();
    s_req[2] = 6'b100000;
    s_req[6] = 6'b010001;
    push_q.push_back('{2, 6'b100000});
    push_q.push_back('{6, 6'b000001});
    push_q.push_back('{6, 6'b010000});
    runScenario("wrap", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter DIGITS, default 6, number of requesters/counter digits (legal 2..8).
REQ-002 Parameter SETTLE_CYCLES, default 17, carry-settle wait after an increment (legal 1..255).
REQ-003 Parameter HOLDOFF_CYCLES, default 10000, debounce lockout after refresh (legal 1..16383).
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  DIGITS  per-digit increment request lines; a request is a rising edge.
REQ-007 enable  input  1  high = accept new edges and issue grants.
REQ-008 clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-009 inc_sel  output  DIGITS  one-hot select of the digit being incremented.
REQ-010 inc_pulse  output  1  one-cycle increment strobe, coincident with inc_sel.
REQ-011 ref_pulse  output  1  one-cycle output-refresh strobe.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 pending  output  DIGITS  captured, not-yet-served requests.
REQ-014 overrun  output  1  sticky flag: a request edge was lost.

Function
REQ-015 All outputs are registered; no combinational input-to-output path.
REQ-016 Edge detect: req_prev register; pending[i] sets at the edge where req[i]=1, req_prev[i]=0 and enable=1.
REQ-017 Edge on req[i] while pending[i]=1 (and not being cleared that cycle): no new pending bit, overrun sets.
REQ-018 Edges with enable=0 are discarded silently; existing pending bits are retained.
REQ-019 FSM states: IDLE, GRANT, SETTLE, REFRESH, HOLDOFF.
REQ-020 IDLE -> GRANT when enable=1 and pending!=0; grant index is the first set pending bit searching upward from last_grant+1, modulo DIGITS.
REQ-021 GRANT lasts 1 cycle: inc_pulse=1, inc_sel=one-hot(grant); pending[grant] clears; last_grant<=grant; cycle counter<=0.
REQ-022 SETTLE lasts exactly SETTLE_CYCLES cycles, then REFRESH.
REQ-023 REFRESH lasts 1 cycle: ref_pulse=1, then HOLDOFF.
REQ-024 HOLDOFF lasts exactly HOLDOFF_CYCLES cycles, then IDLE.
REQ-025 Latency: edge sampled at clock k -> pending set after k -> inc_pulse high in cycle k+1..k+2.
REQ-026 Grant-to-idle: 1+SETTLE_CYCLES+1+HOLDOFF_CYCLES cycles; busy high for exactly that span.
REQ-027 New edge on req[grant] in the GRANT cycle: set wins, pending[grant] stays 1, no overrun.
REQ-028 inc_sel=0 and inc_pulse=0 outside GRANT; ref_pulse=0 outside REFRESH.
REQ-029 Pending edges arriving in SETTLE/REFRESH/HOLDOFF are held and served after HOLDOFF, one sequence per request.
REQ-030 enable dropping mid-sequence does not abort it; the FSM completes to IDLE and stops granting.
REQ-031 clr_ovr=1 clears overrun; a simultaneous overrun event wins (overrun stays 1).
REQ-032 Cycle counter is 14 bits and never wraps within a state.

Reset
REQ-033 Reset forces state IDLE, counter 0, pending 0, overrun 0, inc_sel 0, inc_pulse 0, ref_pulse 0, busy 0.
REQ-034 Reset sets req_prev to all ones, so inputs held high across reset release produce no request.
REQ-035 Reset sets last_grant to DIGITS-1, so the first search starts at digit 0.
REQ-036 Reset mid-sequence aborts immediately; no residual pulse after deassertion.

Verification (DIGITS=6, SETTLE_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-037 Single edge req[2] at clock k -> inc_sel=6'b000100 with inc_pulse in k+1..k+2; ref_pulse 5 cycles after inc_pulse; busy low at cycle k+15.
REQ-038 Simultaneous edges req[0], req[3] after reset -> digit 0 granted first, digit 3 granted 14 cycles later; pending returns to 0.
REQ-039 Second edge on req[1] while pending[1]=1 -> overrun=1, exactly one inc_pulse for digit 1; clr_ovr then -> overrun=0.
REQ-040 req=6'b111111 held through reset release -> no inc_pulse for 50 cycles; busy stays 0.
REQ-041 Reset asserted in SETTLE -> inc_pulse, ref_pulse, busy, pending all 0 within the same cycle; no ref_pulse follows.
REQ-042 enable=0, edge on req[4] -> pending stays 0; no grant after enable returns high.
